// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer. It has no arithmetic of its own:
// every add, subtract and compare is issued to the shared EXU ALU, one op per cycle.
module alu_muldiv_seq #(
    parameter logic [2:0] ALU_ADD = 3'b000,
    parameter logic [2:0] ALU_LTU = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        busy,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_funct,
    output logic        alu_funcs,
    input  logic [31:0] alu_val
);

    localparam logic [2:0]  OpMulh   = 3'b001;
    localparam logic [2:0]  OpMulhsu = 3'b010;
    localparam logic [2:0]  OpMulhu  = 3'b011;
    localparam logic [2:0]  OpRem    = 3'b110;
    localparam logic [31:0] MinInt   = 32'h8000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StNegA,
        StNegB,
        StMul,
        StDivC,
        StDivS,
        StFix,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    // hi/lo hold the product halves for multiplies and rem/quotient for divides.
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic        ge_q, ge_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;

    logic [31:0] sh;
    logic [31:0] sel;
    logic        carry;

    // Operand a is taken as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic sgn_a(input logic [2:0] op);
        return op[2] ? ~op[0] : (op != OpMulhu);
    endfunction

    // Operand b is taken as signed for MUL, MULH, DIV and REM.
    function automatic logic sgn_b(input logic [2:0] op);
        return op[2] ? ~op[0] : ~op[1];
    endfunction

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign out_res   = res_q;

    // Divider shift-in word and the result word picked for this op.
    assign sh  = {hi_q[30:0], lo_q[31]};
    assign sel = op_q[2] ? (op_q[1] ? hi_q : lo_q) : ((op_q[1:0] == 2'b00) ? lo_q : hi_q);

    // Sequencer state register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            ge_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            ge_q    <= ge_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Next-state, datapath update and ALU drive for the current step.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_d     = neg_q;
        ge_d      = ge_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_funct = ALU_ADD;
        alu_funcs = 1'b0;
        carry     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = in_op;
                    cnt_d = '0;
                    b_d   = in_b;
                    ge_d  = 1'b0;
                    if (in_op[2] && (in_b == '0)) begin
                        // Divide by zero: q = all ones, rem = a; one pass-through FIX cycle.
                        hi_d    = in_a;
                        lo_d    = '1;
                        neg_d   = 1'b0;
                        state_d = StFix;
                    end else if (in_op[2] && !in_op[0] && (in_a == MinInt) && (in_b == '1)) begin
                        // Signed overflow: q = MinInt, rem = 0.
                        hi_d    = '0;
                        lo_d    = MinInt;
                        neg_d   = 1'b0;
                        state_d = StFix;
                    end else begin
                        hi_d  = '0;
                        lo_d  = in_a;
                        neg_d = sgn_a(in_op)
                              & (in_a[31] ^ (sgn_b(in_op) & (in_op != OpRem) & in_b[31]));
                        if (sgn_a(in_op)) begin
                            state_d = StNegA;
                        end else if (in_op[2]) begin
                            state_d = StDivC;
                        end else begin
                            state_d = StMul;
                        end
                    end
                end
            end
            StNegA: begin
                alu_funcs = 1'b1;
                alu_b     = lo_q;
                lo_d      = lo_q[31] ? alu_val : lo_q;
                if (sgn_b(op_q)) begin
                    state_d = StNegB;
                end else begin
                    state_d = StMul;
                end
            end
            StNegB: begin
                alu_funcs = 1'b1;
                alu_b     = b_q;
                b_d       = b_q[31] ? alu_val : b_q;
                state_d   = op_q[2] ? StDivC : StMul;
            end
            StMul: begin
                // Adding zero when lo[0] is clear keeps hi unchanged and forces carry to 0.
                alu_a = hi_q;
                alu_b = lo_q[0] ? b_q : '0;
                carry = (hi_q[31] & alu_b[31]) | ((hi_q[31] | alu_b[31]) & ~alu_val[31]);
                hi_d  = {carry, alu_val[31:1]};
                lo_d  = {alu_val[0], lo_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    if (op_q == OpMulhu) begin
                        res_d   = hi_d;
                        state_d = StDone;
                    end else begin
                        state_d = StFix;
                    end
                end
            end
            StDivC: begin
                alu_a     = sh;
                alu_b     = b_q;
                alu_funct = ALU_LTU;
                ge_d      = hi_q[31] | ~alu_val[0];
                state_d   = StDivS;
            end
            StDivS: begin
                alu_a     = sh;
                alu_b     = b_q;
                alu_funcs = 1'b1;
                hi_d      = ge_q ? alu_val : sh;
                lo_d      = {lo_q[30:0], ge_q};
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    if (op_q[0]) begin
                        res_d   = op_q[1] ? hi_d : lo_d;
                        state_d = StDone;
                    end else begin
                        state_d = StFix;
                    end
                end else begin
                    state_d = StDivC;
                end
            end
            StFix: begin
                if (neg_q) begin
                    if ((op_q == OpMulh) || (op_q == OpMulhsu)) begin
                        // High word of the 64-bit two's complement negation.
                        alu_a = ~hi_q;
                        alu_b = {31'b0, (lo_q == '0)};
                    end else begin
                        alu_b     = sel;
                        alu_funcs = 1'b1;
                    end
                    res_d = alu_val;
                end else begin
                    res_d = sel;
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed cases plus randomized ops checked
// against a plain-arithmetic reference model; the shared ALU is modelled here.
module tb_alu_muldiv_seq;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluLtu = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_funct;
    logic        alu_funcs;
    logic [31:0] alu_val;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] corners [5];

    alu_muldiv_seq #(
        .ALU_ADD(AluAdd),
        .ALU_LTU(AluLtu)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .busy     (busy),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_funct(alu_funct),
        .alu_funcs(alu_funcs),
        .alu_val  (alu_val)
    );

    always #5 clk = ~clk;

    // Shared ALU: combinational add/sub and unsigned less-than.
    always_comb begin
        alu_val = '0;
        if (alu_funct == AluAdd) begin
            alu_val = alu_funcs ? (alu_a - alu_b) : (alu_a + alu_b);
        end else if (alu_funct == AluLtu) begin
            alu_val = {31'b0, (alu_a < alu_b)};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV32M results from plain 64-bit / signed arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sb, sr;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin ea = {32'b0, a}; eb = {32'b0, b}; p = ea * eb; return p[31:0]; end
            3'd1: begin
                ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; return p[63:32];
            end
            3'd2: begin ea = {{32{a[31]}}, a}; eb = {32'b0, b}; p = ea * eb; return p[63:32]; end
            3'd3: begin ea = {32'b0, a}; eb = {32'b0, b}; p = ea * eb; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sr = sa / sb;
                return sr;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sr = sa % sb;
                return sr;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        case (op)
            3'd0, 3'd1: return 35;
            3'd2:       return 34;
            3'd3:       return 32;
            3'd5, 3'd7: return (b == 0) ? 1 : 64;
            default:    return ((b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 67;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 15));
            1:       return -32'($urandom_range(1, 15));
            2:       return corners[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    // Per-cycle ALU ownership rules.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("busy_vs_state", {31'b0, busy}, {31'b0, !(in_ready || out_valid)});
            if (!busy) begin
                check_eq("idle_alu_a", alu_a, 32'h0);
                check_eq("idle_alu_b", alu_b, 32'h0);
                check_eq("idle_alu_funct", {29'b0, alu_funct}, {29'b0, AluAdd});
                check_eq("idle_alu_funcs", {31'b0, alu_funcs}, 32'h0);
            end
            if (alu_funcs) begin
                check_eq("funcs_only_sub", {29'b0, alu_funct}, {29'b0, AluAdd});
            end
        end
    end

    // One transaction: accept, time the latency, hold in DONE, then release.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input int hold);
        int lat;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Scramble inputs: they must not be sampled after the accept edge.
        in_valid = 1'b0;
        in_op    = 3'($urandom_range(0, 7));
        in_a     = $urandom;
        in_b     = $urandom;
        lat      = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_result"}, out_res, exp_res);
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, {31'b0, out_valid}, 32'h1);
            check_eq({tag, "_hold_ready"}, {31'b0, in_ready}, 32'h0);
            check_eq({tag, "_hold_res"}, out_res, exp_res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_release_idle"}, {31'b0, in_ready}, 32'h1);
        check_eq({tag, "_release_valid"}, {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        seen_valid;

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_in_ready", {31'b0, in_ready}, 32'h1);
        check_eq("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("reset_busy", {31'b0, busy}, 32'h0);
        check_eq("reset_out_res", out_res, 32'h0);

        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0);
        run_op("mulh_neg", 3'd1, -32'd3, 32'd7, 32'hFFFF_FFFF, 35, 1);
        run_op("mul_neg", 3'd0, -32'd3, 32'd7, 32'hFFFF_FFEB, 35, 0);
        run_op("div_neg", 3'd4, -32'd7, 32'd2, 32'hFFFF_FFFD, 67, 0);
        run_op("rem_neg", 3'd6, -32'd7, 32'd2, 32'hFFFF_FFFF, 67, 2);
        run_op("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
        run_op("mulhsu_neg", 3'd2, -32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        run_op("remu_big", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 64, 10);

        // Reset in the middle of a DIVU aborts it with no output.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd5;
        in_a     = 32'd1000;
        in_b     = 32'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_in_ready", {31'b0, in_ready}, 32'h1);
        check_eq("abort_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("abort_busy", {31'b0, busy}, 32'h0);
        seen_valid = 1'b0;
        repeat (70) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        check_eq("abort_no_output", {31'b0, seen_valid}, 32'h0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            if ((op == 3'd4 || op == 3'd5) && $urandom_range(0, 7) == 0) begin
                b = 32'h0;
            end
            run_op("rand", op, a, b, ref_res(op, a, b), ref_lat(op, a, b),
                   int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
